usb_cmd_responder: RTL

USB_CMD_RESPONDER -- requirements
Module: usb_cmd_responder

---
 rtl/usb_cmd_responder.sv | 311 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_cmd_responder.sv
// Framed register-access responder sitting behind a USB byte bridge.
// Parses A5/CMD/ADDR/LEN/[payload]/CHK requests and performs buffered
// register writes or flow-controlled reads. Every request gets a
// 5A/STATUS/[data]/RCHK response, except one abandoned by the idle timeout.
// Ports:
//   clk_48mhz, reset      clock, synchronous active-low reset
//   rx_data/valid/ready   host-to-device byte stream
//   tx_data/valid/ready   device-to-host byte stream
//   reg_addr/wdata/we/re  register bus request side, reg_rdata one cycle after reg_re
//   err_count             saturating count of checksum errors and timeouts
module usb_cmd_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 48000,
  parameter int unsigned MAX_LEN        = 16
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic [7:0] err_count
);

  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [7:0] SYNC_REQ    = 8'hA5;
  localparam logic [7:0] SYNC_RESP   = 8'h5A;
  localparam logic [7:0] CMD_WR      = 8'h01;
  localparam logic [7:0] CMD_RD      = 8'h02;
  localparam logic [7:0] STS_OK      = 8'h00;
  localparam logic [7:0] STS_BAD_CHK = 8'h01;
  localparam logic [7:0] STS_BAD_CMD = 8'h02;
  localparam logic [7:0] STS_BAD_LEN = 8'h03;

  typedef enum logic [3:0] {
    ST_HUNT, ST_CMD, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK,
    ST_EXEC_WR, ST_EXEC_RD, ST_RESP
  } state_t;

  // Response sub-phase: header, status, trailing checksum
  typedef enum logic [1:0] { RP_HDR, RP_STAT, RP_RCHK } resp_ph_t;

  // Read sub-phase: strobe, wait for data, capture to tx, wait for consume
  typedef enum logic [1:0] { RD_ISSUE, RD_WAIT, RD_CAPTURE, RD_SEND } rd_ph_t;

  state_t      state_q, state_d;
  resp_ph_t    rp_q, rp_d;
  rd_ph_t      rd_q, rd_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  status_q, status_d;
  logic [7:0]  rchk_q, rchk_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic        rx_ready_d, tx_valid_d, reg_we_d, reg_re_d;
  logic [7:0]  tx_data_d, reg_addr_d, reg_wdata_d, err_count_d;
  logic        err_inc;
  logic        rx_fire;
  logic        in_frame;
  logic [7:0]  pbuf [MAX_LEN];

  assign rx_fire  = rx_valid & rx_ready;
  assign in_frame = state_q inside {ST_CMD, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK};

  // Write payload store; only committed to the bus once CHK matches
  always_ff @(posedge clk_48mhz) begin
    if (state_q == ST_PAYLOAD && rx_fire) begin
      pbuf[IDX_W'(cnt_q)] <= rx_data;
    end
  end

  // State and output registers
  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      state_q   <= ST_HUNT;
      rp_q      <= RP_HDR;
      rd_q      <= RD_ISSUE;
      cmd_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      chk_q     <= '0;
      status_q  <= '0;
      rchk_q    <= '0;
      idle_q    <= '0;
      rx_ready  <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      err_count <= '0;
    end else begin
      state_q   <= state_d;
      rp_q      <= rp_d;
      rd_q      <= rd_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      status_q  <= status_d;
      rchk_q    <= rchk_d;
      idle_q    <= idle_d;
      rx_ready  <= rx_ready_d;
      tx_data   <= tx_data_d;
      tx_valid  <= tx_valid_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      reg_we    <= reg_we_d;
      reg_re    <= reg_re_d;
      err_count <= err_count_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rp_d        = rp_q;
    rd_d        = rd_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    status_d    = status_q;
    rchk_d      = rchk_q;
    idle_d      = '0;
    tx_data_d   = tx_data;
    tx_valid_d  = tx_valid;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    err_inc     = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (rx_fire && rx_data == SYNC_REQ) begin
          state_d = ST_CMD;
          chk_d   = '0;
        end
      end
      ST_CMD: begin
        if (rx_fire) begin
          cmd_d   = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          addr_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_fire) begin
          len_d = rx_data;
          chk_d = chk_q ^ rx_data;
          cnt_d = '0;
          rp_d  = RP_HDR;
          if (cmd_q != CMD_WR && cmd_q != CMD_RD) begin
            status_d = STS_BAD_CMD;
            state_d  = ST_RESP;
          end else if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            status_d = STS_BAD_LEN;
            state_d  = ST_RESP;
          end else if (cmd_q == CMD_WR) begin
            state_d = ST_PAYLOAD;
          end else begin
            state_d = ST_CHK;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_fire) begin
          chk_d = chk_q ^ rx_data;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) begin
            state_d = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (rx_fire) begin
          rp_d = RP_HDR;
          if (rx_data != chk_q) begin
            status_d = STS_BAD_CHK;
            err_inc  = 1'b1;
            state_d  = ST_RESP;
          end else if (cmd_q == CMD_WR) begin
            // First write goes out the cycle right after CHK is accepted
            status_d    = STS_OK;
            reg_we_d    = 1'b1;
            reg_addr_d  = addr_q;
            reg_wdata_d = pbuf[0];
            cnt_d       = 8'd1;
            state_d     = ST_EXEC_WR;
          end else begin
            status_d = STS_OK;
            state_d  = ST_RESP;
          end
        end
      end
      ST_EXEC_WR: begin
        // cnt_q counts strobes already issued
        if (cnt_q < len_q) begin
          reg_we_d    = 1'b1;
          reg_addr_d  = reg_addr + 8'd1;
          reg_wdata_d = pbuf[IDX_W'(cnt_q)];
          cnt_d       = cnt_q + 8'd1;
        end else begin
          rp_d    = RP_HDR;
          state_d = ST_RESP;
        end
      end
      ST_EXEC_RD: begin
        case (rd_q)
          RD_ISSUE: begin
            reg_re_d   = 1'b1;
            reg_addr_d = addr_q + cnt_q;
            rd_d       = RD_WAIT;
          end
          RD_WAIT: rd_d = RD_CAPTURE;
          RD_CAPTURE: begin
            tx_data_d  = reg_rdata;
            tx_valid_d = 1'b1;
            rchk_d     = rchk_q ^ reg_rdata;
            rd_d       = RD_SEND;
          end
          RD_SEND: begin
            // Next strobe waits until this byte has been consumed
            if (tx_ready) begin
              tx_valid_d = 1'b0;
              if (cnt_q + 8'd1 == len_q) begin
                rp_d    = RP_RCHK;
                state_d = ST_RESP;
              end else begin
                cnt_d = cnt_q + 8'd1;
                rd_d  = RD_ISSUE;
              end
            end
          end
          default: rd_d = RD_ISSUE;
        endcase
      end
      ST_RESP: begin
        if (!tx_valid) begin
          tx_valid_d = 1'b1;
          case (rp_q)
            RP_HDR: begin
              tx_data_d = SYNC_RESP;
              rchk_d    = status_q;
            end
            RP_STAT: tx_data_d = status_q;
            default: tx_data_d = rchk_q;
          endcase
        end else if (tx_ready) begin
          tx_valid_d = 1'b0;
          case (rp_q)
            RP_HDR: rp_d = RP_STAT;
            RP_STAT: begin
              if (cmd_q == CMD_RD && status_q == STS_OK) begin
                cnt_d   = '0;
                rd_d    = RD_ISSUE;
                state_d = ST_EXEC_RD;
              end else begin
                rp_d = RP_RCHK;
              end
            end
            default: state_d = ST_HUNT;
          endcase
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Inter-byte timeout while a request is being received
    if (in_frame && !rx_fire) begin
      if (idle_q == IDLE_LAST) begin
        state_d = ST_HUNT;
        err_inc = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    err_count_d = err_count;
    if (err_inc && err_count != 8'hFF) begin
      err_count_d = err_count + 8'd1;
    end

    rx_ready_d = state_d inside {ST_HUNT, ST_CMD, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK};
  end

endmodule
